cdc_event_tx: RTL

Multi-channel transmit side of a clock-domain-crossing event propagator with a parametrised synchroniser. Each channel converts single-cycle event pulses in the source domain into a level-based four-phase request/acknowledge handshake toward a receiver in a foreign clock domain. Events arriving while a handshake is in flight are counted rather than lost. The block sits in the source domain, wired point-to-point to a matching receiver through `valid_o`/`ack_i`.

---
 rtl/cdc_event_pkg.sv | 13 +
 rtl/cdc_event_tx_chan.sv | 84 ++++++++
 rtl/cdc_event_tx.sv | 42 ++++
 3 files changed

// File: rtl/cdc_event_pkg.sv
// Shared types for the CDC event propagator.
// Channel FSM encoding and synchroniser depth floor.
package cdc_event_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } chan_state_e;

    localparam int unsigned SyncStagesMin = 2;

endpackage

// File: rtl/cdc_event_tx_chan.sv
// One transmit channel: ack synchroniser, four-phase FSM,
// pending-event counter and sticky overflow flag.
module cdc_event_tx_chan
    import cdc_event_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned CntWidth   = 3
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                valid_i,
    input  logic                ack_i,
    input  logic                clr_ovf_i,
    output logic                valid_o,
    output logic [CntWidth-1:0] pending_o,
    output logic                overflow_o,
    output logic                busy_o
);

    localparam int unsigned Stages =
        (SyncStages < SyncStagesMin) ? SyncStagesMin : SyncStages;

    (* async_reg = "true" *) logic [Stages-1:0] sync_q;
    logic [Stages-1:0] sync_d;
    logic              ack_s;

    chan_state_e       state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              take, inc, dec, ovf_set;

    assign ack_s = sync_q[Stages-1];

    always_comb begin
        sync_d  = {sync_q[Stages-2:0], ack_i};
        take    = (state_q == IDLE) && (valid_i || (cnt_q != '0));
        dec     = take && (cnt_q != '0);
        // The only way an event is consumed is a direct launch from empty.
        inc     = valid_i && !(take && (cnt_q == '0));
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_set = 1'b0;

        unique case (state_q)
            IDLE:     if (take)   state_d = REQ;
            REQ:      if (ack_s)  state_d = WAIT_LOW;
            WAIT_LOW: if (!ack_s) state_d = IDLE;
            default:              state_d = IDLE;
        endcase

        if (inc && !dec) begin
            if (cnt_q == '1) ovf_set = 1'b1;
            else             cnt_d   = cnt_q + CntWidth'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CntWidth'(1);
        end

        ovf_d   = ovf_set | (ovf_q & ~clr_ovf_i);
        valid_d = (state_d == REQ);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o    = valid_q;
    assign pending_o  = cnt_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: rtl/cdc_event_tx.sv
// Multi-channel CDC event transmitter: one independent
// handshake channel per event line.
module cdc_event_tx
    import cdc_event_pkg::*;
#(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned SyncStages  = 2,
    parameter int unsigned CntWidth    = 3
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NumChannels-1:0]          valid_i,
    input  logic [NumChannels-1:0]          ack_i,
    input  logic                            clr_ovf_i,
    output logic [NumChannels-1:0]          valid_o,
    output logic [NumChannels*CntWidth-1:0] pending_o,
    output logic [NumChannels-1:0]          overflow_o,
    output logic                            busy_o
);

    logic [NumChannels-1:0] chan_busy;

    for (genvar i = 0; i < NumChannels; i++) begin : g_chan
        cdc_event_tx_chan #(
            .SyncStages (SyncStages),
            .CntWidth   (CntWidth)
        ) u_chan (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .valid_i    (valid_i[i]),
            .ack_i      (ack_i[i]),
            .clr_ovf_i  (clr_ovf_i),
            .valid_o    (valid_o[i]),
            .pending_o  (pending_o[i*CntWidth +: CntWidth]),
            .overflow_o (overflow_o[i]),
            .busy_o     (chan_busy[i])
        );
    end

    assign busy_o = |chan_busy;

endmodule
